keypad_scan_onehot: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces it and drives the 16-bit one-hot key bus consumed by the password/display controller, using one bit per key and 16'h0000 for no key. It sits between the board keypad pins and the one-hot-to-binary controller. The bus holds a level while a key is held and returns to zero on release. It also issues a single-cycle strobe and a 4-bit key index on each new key.

---
 rtl/keypad_scan_onehot.sv | 113 +++++++++++
 tb/tb_keypad_scan_onehot.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_onehot.sv
// 4x4 active-low keypad scanner: column drive, row synchronizer, whole-scan debounce,
// and a one-hot key level with a strobe and a 4-bit index for each new key.
module keypad_scan_onehot #(
    parameter int SCAN_CYCLES    = 50000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] onehot,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [1:0]    r_col_idx;
    logic [DW-1:0] r_dwell;
    logic [15:0]   r_raw;
    logic [15:0]   r_prev;
    logic [SW-1:0] r_stable;
    logic [15:0]   r_onehot;
    logic          r_key_valid;
    logic [3:0]    r_key_code;

    logic          w_sample;
    logic          w_scan_done;
    logic [15:0]   w_snapshot;
    logic [SW-1:0] w_stable_next;
    logic [15:0]   w_filtered;
    logic [3:0]    w_index;
    logic          w_commit;

    assign w_sample    = (r_dwell == DWELL_LAST);
    assign w_scan_done = w_sample && (r_col_idx == 2'd3);

    // Snapshot is the stored columns with the current column's rows merged in,
    // so on the column-3 sample edge it already holds the full scan.
    always_comb begin
        w_snapshot = r_raw;
        for (int r = 0; r < 4; r++) begin
            w_snapshot[{2'(r), r_col_idx}] = ~r_sync2[r];
        end
    end

    always_comb begin
        w_stable_next = '0;
        if (w_snapshot == r_prev) begin
            w_stable_next = (r_stable == STABLE_MAX) ? STABLE_MAX : r_stable + SW'(1);
        end
    end

    // Multi-key and ghost patterns are treated as no key.
    assign w_filtered = ($countones(w_snapshot) == 1) ? w_snapshot : 16'h0000;

    always_comb begin
        w_index = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (w_filtered[i]) w_index = 4'(i);
        end
    end

    assign w_commit = w_scan_done && (w_stable_next == STABLE_MAX) && (w_filtered != r_onehot);

    always_ff @(posedge clk) begin
        if (RSTn) begin
            r_sync1     <= 4'b1111;
            r_sync2     <= 4'b1111;
            r_col_idx   <= 2'd0;
            r_dwell     <= '0;
            r_raw       <= 16'h0000;
            r_prev      <= 16'h0000;
            r_stable    <= '0;
            r_onehot    <= 16'h0000;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
        end else begin
            r_sync1     <= row_in;
            r_sync2     <= r_sync1;
            r_key_valid <= 1'b0;
            if (w_sample) begin
                r_dwell   <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                r_raw     <= w_snapshot;
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
            if (w_scan_done) begin
                r_prev   <= w_snapshot;
                r_stable <= w_stable_next;
            end
            if (w_commit) begin
                r_onehot <= w_filtered;
                if (|w_filtered) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_index;
                end
            end
        end
    end

    assign col_out   = ~(4'b0001 << r_col_idx);
    assign onehot    = r_onehot;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_scan_onehot.sv
// Directed bench for keypad_scan_onehot: keypad model, expected-key scoreboard popped on
// each key_valid strobe, and continuous onehot/strobe sanity checks.
module tb_keypad_scan_onehot;

    localparam int SC  = 4;
    localparam int DB  = 3;
    localparam int LAT = (DB + 2) * 4 * SC + 2;

    logic        clk;
    logic        RSTn;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] onehot;
    logic        key_valid;
    logic [3:0]  key_code;

    logic [15:0] keys;

    typedef struct {
        logic [15:0] oh;
        logic [3:0]  code;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;
    logic prev_kv = 1'b0;
    logic mon_restrict = 1'b0;
    logic [15:0] allow_a = 16'h0000;
    logic [15:0] allow_b = 16'h0000;

    keypad_scan_onehot #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .RSTn      (RSTn),
        .row_in    (row_in),
        .col_out   (col_out),
        .onehot    (onehot),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A held key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (|(keys[4*r +: 4] & ~col_out)) row_in[r] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_onehot(input logic [15:0] expv, input string tag, output int cyc);
        cyc = 0;
        while (onehot !== expv && cyc < LAT) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(onehot), 32'(expv));
    endtask

    always @(negedge clk) begin
        if (!RSTn) begin
            check("onehot_popcount", 32'($countones(onehot) <= 1), 32'd1);
            if (mon_restrict)
                check("onehot_allowed", 32'((onehot === allow_a) || (onehot === allow_b)), 32'd1);
            if (key_valid) begin
                exp_t e;
                pulse_cnt++;
                check("kv_gap", 32'(prev_kv), 32'd0);
                check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pulse_onehot", 32'(onehot), 32'(e.oh));
                    check("pulse_code", 32'(key_code), 32'(e.code));
                end
            end
        end
        prev_kv = key_valid;
    end

    initial begin
        int cyc;
        int p0;
        int elapsed;
        int d;
        exp_t e;

        RSTn = 1'b1;
        keys = 16'h0000;
        repeat (3) @(posedge clk);
        #1 RSTn = 1'b0;
        @(negedge clk);
        check("rst_col_out", 32'(col_out), 32'h0000000e);
        check("rst_onehot", 32'(onehot), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_code", 32'(key_code), 32'h0);
        for (int k = 0; k <= 16; k++) begin
            logic [3:0] one;
            one = 4'b0001;
            check("col_step", 32'(col_out), 32'(~(one << ((k / SC) % 4)) & 4'hf));
            @(negedge clk);
        end

        // Single key row1/col2, press then release
        p0 = pulse_cnt;
        e.oh = 16'h0040; e.code = 4'd6; exp_q.push_back(e);
        keys[6] = 1'b1;
        wait_onehot(16'h0040, "press_k6", cyc);
        repeat (3) @(negedge clk);
        check("press_k6_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("press_k6_code", 32'(key_code), 32'd6);
        p0 = pulse_cnt;
        keys[6] = 1'b0;
        wait_onehot(16'h0000, "release_k6", cyc);
        repeat (3) @(negedge clk);
        check("release_k6_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("release_k6_code", 32'(key_code), 32'd6);

        // Bounce on key 0, then steady hold
        p0 = pulse_cnt;
        allow_a = 16'h0000; allow_b = 16'h0001; mon_restrict = 1'b1;
        e.oh = 16'h0001; e.code = 4'd0; exp_q.push_back(e);
        elapsed = 0;
        while (elapsed < 60) begin
            d = int'($urandom_range(9, 3));
            repeat (d) @(negedge clk);
            keys[0] = ~keys[0];
            elapsed += d;
        end
        keys[0] = 1'b1;
        wait_onehot(16'h0001, "bounce_k0", cyc);
        repeat (40) @(negedge clk);
        check("bounce_pulses", 32'(pulse_cnt - p0), 32'd1);
        mon_restrict = 1'b0;

        // Multi-key 0 + 15 is filtered to no key
        keys[0] = 1'b0;
        wait_onehot(16'h0000, "release_k0", cyc);
        repeat (2) @(negedge clk);
        p0 = pulse_cnt;
        allow_a = 16'h0000; allow_b = 16'h0000; mon_restrict = 1'b1;
        keys[0] = 1'b1; keys[15] = 1'b1;
        repeat (200) @(negedge clk);
        check("multi_onehot", 32'(onehot), 32'h0);
        check("multi_pulses", 32'(pulse_cnt - p0), 32'd0);
        mon_restrict = 1'b0;
        e.oh = 16'h0001; e.code = 4'd0; exp_q.push_back(e);
        keys[15] = 1'b0;
        wait_onehot(16'h0001, "multi_release_k15", cyc);
        repeat (3) @(negedge clk);
        check("multi_release_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Key change 3 -> 8 without release
        keys[0] = 1'b0;
        wait_onehot(16'h0000, "release_k0b", cyc);
        p0 = pulse_cnt;
        e.oh = 16'h0008; e.code = 4'd3; exp_q.push_back(e);
        keys[3] = 1'b1;
        wait_onehot(16'h0008, "press_k3", cyc);
        repeat (2) @(negedge clk);
        allow_a = 16'h0008; allow_b = 16'h0100; mon_restrict = 1'b1;
        e.oh = 16'h0100; e.code = 4'd8; exp_q.push_back(e);
        keys[3] = 1'b0; keys[8] = 1'b1;
        wait_onehot(16'h0100, "change_k8", cyc);
        repeat (3) @(negedge clk);
        mon_restrict = 1'b0;
        check("change_pulses", 32'(pulse_cnt - p0), 32'd2);
        check("change_code", 32'(key_code), 32'd8);

        // Reset while key 5 is committed
        keys[8] = 1'b0;
        wait_onehot(16'h0000, "release_k8", cyc);
        e.oh = 16'h0020; e.code = 4'd5; exp_q.push_back(e);
        keys[5] = 1'b1;
        wait_onehot(16'h0020, "press_k5", cyc);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 RSTn = 1'b1;
        @(posedge clk);
        #1 RSTn = 1'b0;
        @(negedge clk);
        check("midrst_onehot", 32'(onehot), 32'h0);
        check("midrst_col_out", 32'(col_out), 32'h0000000e);
        check("midrst_key_valid", 32'(key_valid), 32'h0);
        check("midrst_key_code", 32'(key_code), 32'h0);
        p0 = pulse_cnt;
        e.oh = 16'h0020; e.code = 4'd5; exp_q.push_back(e);
        wait_onehot(16'h0020, "recommit_k5", cyc);
        check("recommit_min_latency", 32'(cyc >= DB * 4 * SC), 32'd1);
        repeat (3) @(negedge clk);
        check("recommit_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("recommit_code", 32'(key_code), 32'd5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
